qam_mapper_multi: RTL and testbench
===================================

# qam_mapper_multi

Multi-mode Gray-coded QAM symbol mapper for the transmitter chain. It takes a serial bit stream under a valid/ready handshake and assembles symbols of 2, 4 or 6 bits (QPSK, 16-QAM, 64-QAM). Each symbol is mapped to signed I/Q amplitude words and presented downstream under a second valid/ready handshake. It sits between the bit source/scrambler and the pulse-shaping filter, and supports frame-end padding and output backpressure.

## Interface
- width_data, 16, width of each I/Q output word; legal range 8..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  00 = QPSK (k=2), 01 = 16-QAM (k=4), 10 = 64-QAM (k=6), 11 = reserved.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_last  in  1  qualifies the accepted bit as the last bit of a frame.
- bit_ready  out  1  mapper can accept a bit this cycle; combinational.
- sym_I  out  width_data  signed in-phase amplitude.
- sym_Q  out  width_data  signed quadrature amplitude.
- sym_valid  out  1  sym_I, sym_Q and sym_last hold a symbol.
- sym_last  out  1  this symbol ends a frame.
- sym_ready  in  1  downstream accepts the symbol this cycle.
- mode_err  out  1  sticky flag: reserved mode was latched.

## Operation
- A bit is accepted on an edge where bit_valid && bit_ready.
- Symbol assembly:
  - mode_q is latched on the accepted bit when bit_cnt == 0 and is held for the whole symbol.
  - Mode changes mid-symbol are ignored.
  - Mode 11 is latched as QPSK and sets mode_err. mode_err is cleared only by rst.
- Bit order: the first k/2 accepted bits form the I field and the next k/2 form the Q field. Within each field the first bit is the MSB.
- Level mapping is per axis, Gray-coded:
  - QPSK: 0 -> -1, 1 -> +1.
  - 16-QAM: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
  - 64-QAM: 000 -> -7, 001 -> -5, 011 -> -3, 010 -> -1, 110 -> +1, 111 -> +3, 101 -> +5, 100 -> +7.
- Output format: the level is a 4-bit two's-complement value placed in the top 4 bits of the output word, with the remaining width_data-4 LSBs zero. For width_data=16 this is level × 4096.
- Completing a symbol: the symbol completes on the accepted bit where bit_cnt == k-1, or on any accepted bit with bit_last=1.
  - On that same edge the mapped symbol loads the output register, sym_valid is set, and bit_cnt returns to 0.
  - Missing bits of a short (bit_last) symbol are zero-padded, and sym_last is set.
- bit_last on the final bit of a full symbol gives a normal symbol with sym_last=1.
- bit_ready = !(bit_cnt == k_eff-1 && sym_valid && !sym_ready).
  - k_eff is the k of mode_q, or of mode when bit_cnt == 0.
  - Stalling also applies to any bit carrying bit_last while the output register is full and not draining.
- Output register:
  - It holds its contents while sym_valid && !sym_ready.
  - sym_valid clears on the edge where sym_ready=1, unless a new symbol loads on the same edge; in that case the new symbol replaces the old one and sym_valid stays 1.

## Timing
- Reset (async assert, any time, including mid-symbol):
  - sym_I = sym_Q = 0, sym_valid = 0, sym_last = 0, mode_err = 0.
  - bit_cnt = 0, shift register = 0.
  - bit_ready = 1 while in reset and after release.
- Latency: sym_valid rises on the same edge that accepts the completing bit, i.e. visible one cycle after that bit is presented.
- Throughput: one bit per clock. No bubbles while sym_ready=1.
- Minimum symbol period is k cycles. A QPSK symbol can be replaced every 2 cycles.
- Bits presented while bit_valid=0 are ignored. bit_last without bit_valid is ignored.
- bit_cnt never exceeds k-1, and wraps to 0 on each completed symbol.

## Test plan
- QPSK, width_data=16: bits 1,0 -> one symbol with sym_I=0x1000, sym_Q=0xF000, sym_last=0, sym_valid=1 on the edge accepting the 2nd bit.
- 16-QAM: bits 1,0,0,1 then 0,0,1,1 -> two symbols: (0x3000, 0xF000) then (0xD000, 0x1000), with no stall at sym_ready=1.
- 64-QAM: bits 1,0,0,0,0,0 -> (0x7000, 0x9000). Then bits 0,1,0,1,0,1 -> (0xF000, 0x5000).
- Padding: 16-QAM, bits 1,1 with bit_last on the 2nd -> (0x1000, 0xD000), sym_last=1, bit_cnt=0; the next bit starts a new symbol.
- Backpressure: 16-QAM, sym_ready held 0 after the first symbol.
  - The 4th bit of the second symbol sees bit_ready=0, and the first symbol's outputs stay stable.
  - Raising sym_ready for one cycle accepts the stalled bit; the second symbol replaces the first with sym_valid held at 1.
- Reserved mode and reset:
  - mode=11 with bits 0,1 -> (0xF000, 0x1000) and mode_err=1. mode_err persists after the mode changes.
  - rst asserted after 3 of 6 bits in 64-QAM -> all outputs 0 immediately; the next 6 bits form a fresh symbol.

Source files
------------

// File: rtl/qam_mapper_multi.sv
// Gray-coded QPSK/16-QAM/64-QAM mapper: serial bits in, signed I/Q words out.
// Ports: clk, rst (async high); bit_* handshake in; sym_* handshake out; mode_err sticky.
module qam_mapper_multi #(
  parameter int width_data = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  bit_last,
  output logic                  bit_ready,
  output logic [width_data-1:0] sym_I,
  output logic [width_data-1:0] sym_Q,
  output logic                  sym_valid,
  output logic                  sym_last,
  input  logic                  sym_ready,
  output logic                  mode_err
);

  // sel: 0 = QPSK, 1 = 16-QAM, 2 = 64-QAM (reserved folds to QPSK)
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [5:0]            shreg_q, shreg_d;
  logic [1:0]            mode_q, mode_d;
  logic                  mode_err_q, mode_err_d;
  logic [width_data-1:0] sym_i_q, sym_i_d;
  logic [width_data-1:0] sym_q_q, sym_q_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  sym_last_q, sym_last_d;

  logic [1:0] sel_in, sel_eff;
  logic       at_end, accept, complete;
  logic [5:0] bits_now;
  logic [2:0] g_i, g_q;
  logic [3:0] lvl_i, lvl_q;

  // Gray code -> binary index n, then level = 2n - (2^m - 1).
  function automatic logic [3:0] map_lvl(
    input logic [2:0] g,
    input logic [1:0] sel
  );
    logic [2:0] n;
    logic [2:0] ofs;
    n[2] = g[2];
    n[1] = g[2] ^ g[1];
    n[0] = n[1] ^ g[0];
    ofs  = {sel[1], |sel, 1'b1};
    return {n, 1'b0} - {1'b0, ofs};
  endfunction

  always_comb begin
    sel_in   = (mode == 2'b11) ? 2'b00 : mode;
    sel_eff  = (bit_cnt_q == 3'd0) ? sel_in : mode_q;
    at_end   = (bit_cnt_q == {sel_eff, 1'b1});
    // A completing bit may not overwrite a symbol that is still waiting.
    bit_ready = !((at_end || (bit_valid && bit_last))
                  && sym_valid_q && !sym_ready);
    accept   = bit_valid && bit_ready;
    complete = accept && (at_end || bit_last);

    // Positions past bit_cnt are still zero, which gives the padding.
    bits_now = shreg_q;
    bits_now[bit_cnt_q] = bit_in;

    case (sel_eff)
      2'd0: begin
        g_i = {2'b00, bits_now[0]};
        g_q = {2'b00, bits_now[1]};
      end
      2'd1: begin
        g_i = {1'b0, bits_now[0], bits_now[1]};
        g_q = {1'b0, bits_now[2], bits_now[3]};
      end
      default: begin
        g_i = {bits_now[0], bits_now[1], bits_now[2]};
        g_q = {bits_now[3], bits_now[4], bits_now[5]};
      end
    endcase
    lvl_i = map_lvl(g_i, sel_eff);
    lvl_q = map_lvl(g_q, sel_eff);

    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    mode_d      = mode_q;
    mode_err_d  = mode_err_q;
    sym_i_d     = sym_i_q;
    sym_q_d     = sym_q_q;
    sym_last_d  = sym_last_q;
    sym_valid_d = sym_valid_q && !sym_ready;

    if (accept) begin
      if (bit_cnt_q == 3'd0) begin
        mode_d = sel_in;
        if (mode == 2'b11) mode_err_d = 1'b1;
      end
      if (complete) begin
        bit_cnt_d   = 3'd0;
        shreg_d     = 6'd0;
        sym_i_d     = {lvl_i, {(width_data-4){1'b0}}};
        sym_q_d     = {lvl_q, {(width_data-4){1'b0}}};
        sym_last_d  = bit_last;
        sym_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        shreg_d   = bits_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      mode_q      <= '0;
      mode_err_q  <= 1'b0;
      sym_i_q     <= '0;
      sym_q_q     <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      mode_q      <= mode_d;
      mode_err_q  <= mode_err_d;
      sym_i_q     <= sym_i_d;
      sym_q_q     <= sym_q_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
    end
  end

  assign sym_I     = sym_i_q;
  assign sym_Q     = sym_q_q;
  assign sym_valid = sym_valid_q;
  assign sym_last  = sym_last_q;
  assign mode_err  = mode_err_q;

endmodule

// File: tb/tb_qam_mapper_multi.sv
// Bench for qam_mapper_multi: directed plan cases plus randomized traffic,
// with a table-driven reference model feeding a scoreboard queue.
module tb_qam_mapper_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        bit_in, bit_valid, bit_last, bit_ready;
  logic [15:0] sym_I, sym_Q;
  logic        sym_valid, sym_last, sym_ready, mode_err;

  qam_mapper_multi #(.width_data(16)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
    .bit_ready(bit_ready),
    .sym_I(sym_I), .sym_Q(sym_Q),
    .sym_valid(sym_valid), .sym_last(sym_last),
    .sym_ready(sym_ready), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   m_cnt  = 0;
  int   m_k    = 2;
  int   m_bits[6];
  bit   m_err  = 0;
  bit   rr_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic int lvl(input int g, input int h);
    int t1[2] = '{-1, 1};
    int t2[4] = '{-3, -1, 3, 1};
    int t3[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};
    if (h == 1) return t1[g];
    if (h == 2) return t2[g];
    return t3[g];
  endfunction

  function automatic logic [15:0] word(input int l);
    return 16'(l * 4096);
  endfunction

  task automatic model_accept(input int b, input int l, input int m);
    int h, gi, gq;
    exp_t e;
    if (m_cnt == 0) begin
      m_k = (m == 3) ? 2 : 2 * (m + 1);
      if (m == 3) m_err = 1;
      for (int j = 0; j < 6; j++) m_bits[j] = 0;
    end
    m_bits[m_cnt] = b;
    m_cnt++;
    if (m_cnt == m_k || l != 0) begin
      h = m_k / 2;
      gi = 0;
      gq = 0;
      for (int j = 0; j < h; j++) begin
        gi = gi * 2 + m_bits[j];
        gq = gq * 2 + m_bits[h + j];
      end
      e.i = word(lvl(gi, h));
      e.q = word(lvl(gq, h));
      e.last = (l != 0);
      sbq.push_back(e);
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1 with the bit already driven.
  task automatic wait_accept(input int b, input int l, input int m);
    int w = 0;
    bit ok = 0;
    while (w < 60) begin
      @(negedge clk);
      if (bit_ready) begin
        ok = 1;
        break;
      end
      w++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: bit_ready stuck at %b required 1",
               bit_ready);
      @(posedge clk);
    end else begin
      if (w > 0) stalls++;
      @(posedge clk);
      model_accept(b, l, m);
    end
    #1;
    bit_valid = 1'b0;
    bit_last  = 1'b0;
  endtask

  task automatic drive_bit(input int b, input int l, input int m);
    bit_in    = b[0];
    bit_last  = l[0];
    mode      = m[1:0];
    bit_valid = 1'b1;
  endtask

  task automatic send_bit(input int b, input int l, input int m);
    drive_bit(b, l, m);
    wait_accept(b, l, m);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sym_valid && sym_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got I=%h Q=%h required no symbol",
                   sym_I, sym_Q);
        end else begin
          e = sbq.pop_front();
          chk("sb_I", sym_I, e.i);
          chk("sb_Q", sym_Q, e.q);
          chk("sb_last", sym_last, e.last);
          chk("sb_err", mode_err, m_err);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_en) sym_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    mode = 2'b00;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    bit_last = 1'b0;
    sym_ready = 1'b1;
    #1;
    chk("rst_ready", bit_ready, 1);
    chk("rst_valid", sym_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_I", sym_I, 0);
    chk("rel_Q", sym_Q, 0);
    chk("rel_last", sym_last, 0);
    chk("rel_err", mode_err, 0);
    chk("rel_ready", bit_ready, 1);

    // QPSK 1,0
    send_bit(1, 0, 0);
    send_bit(0, 0, 0);
    @(negedge clk);
    chk("qpsk_valid", sym_valid, 1);
    chk("qpsk_I", sym_I, 16'h1000);
    chk("qpsk_Q", sym_Q, 16'hF000);
    chk("qpsk_last", sym_last, 0);
    idle(1);

    // 16-QAM back to back, no stalls
    stalls = 0;
    send_bit(1, 0, 1); send_bit(0, 0, 1);
    send_bit(0, 0, 1); send_bit(1, 0, 1);
    send_bit(0, 0, 1); send_bit(0, 0, 1);
    send_bit(1, 0, 1); send_bit(1, 0, 1);
    chk("qam16_nostall", stalls, 0);

    // 64-QAM
    send_bit(1, 0, 2); send_bit(0, 0, 2); send_bit(0, 0, 2);
    send_bit(0, 0, 2); send_bit(0, 0, 2); send_bit(0, 0, 2);
    send_bit(0, 0, 2); send_bit(1, 0, 2); send_bit(0, 0, 2);
    send_bit(1, 0, 2); send_bit(0, 0, 2); send_bit(1, 0, 2);
    idle(2);

    // Padding
    send_bit(1, 0, 1);
    send_bit(1, 1, 1);
    @(negedge clk);
    chk("pad_I", sym_I, 16'hD000 ^ 16'hC000);
    chk("pad_Q", sym_Q, 16'hD000);
    chk("pad_last", sym_last, 1);
    idle(1);
    send_bit(0, 0, 1); send_bit(1, 0, 1);
    send_bit(1, 0, 1); send_bit(0, 0, 1);
    idle(3);

    // Backpressure
    sym_ready = 1'b0;
    send_bit(1, 0, 1); send_bit(0, 0, 1);
    send_bit(0, 0, 1); send_bit(1, 0, 1);
    send_bit(0, 0, 1); send_bit(0, 0, 1); send_bit(1, 0, 1);
    drive_bit(1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", bit_ready, 0);
      chk("bp_hold_I", sym_I, 16'h3000);
      chk("bp_hold_Q", sym_Q, 16'hF000);
    end
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    wait_accept(1, 0, 1);
    sym_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid", sym_valid, 1);
    chk("bp_new_I", sym_I, 16'hD000);
    chk("bp_new_Q", sym_Q, 16'h1000);
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    idle(2);

    // Reserved mode
    send_bit(0, 0, 3);
    send_bit(1, 0, 3);
    @(negedge clk);
    chk("rsv_err", mode_err, 1);
    chk("rsv_I", sym_I, 16'hF000);
    chk("rsv_Q", sym_Q, 16'h1000);
    idle(1);
    send_bit(1, 0, 0);
    send_bit(1, 0, 0);
    @(negedge clk);
    chk("rsv_sticky", mode_err, 1);
    idle(2);

    // Reset mid-symbol
    chk("pre_rst_empty", sbq.size(), 0);
    send_bit(1, 0, 2); send_bit(1, 0, 2); send_bit(0, 0, 2);
    rst = 1'b1;
    #1;
    chk("mrst_valid", sym_valid, 0);
    chk("mrst_I", sym_I, 0);
    chk("mrst_Q", sym_Q, 0);
    chk("mrst_err", mode_err, 0);
    chk("mrst_ready", bit_ready, 1);
    m_cnt = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_bit(0, 0, 2); send_bit(0, 0, 2); send_bit(0, 0, 2);
    send_bit(1, 0, 2); send_bit(1, 0, 2); send_bit(1, 0, 2);
    @(negedge clk);
    chk("fresh_I", sym_I, 16'h9000);
    chk("fresh_Q", sym_Q, 16'h3000);
    idle(1);

    // Random traffic
    rr_en = 1;
    for (int t = 0; t < 600; t++) begin
      if ($urandom % 5 == 0) begin
        bit_valid = 1'b0;
        bit_last  = 1'($urandom);
        bit_in    = 1'($urandom);
        idle(1);
        bit_last  = 1'b0;
      end
      send_bit($urandom % 2, ($urandom % 10) == 0 ? 1 : 0,
               $urandom % 4);
    end
    rr_en = 0;
    @(posedge clk);
    #1;
    sym_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
